maze_nav_sm: RTL

Travel-plan sequencer for the MazeRunner. It accepts the 16-bit travel-plan command from the UART wrapper. Each time a gap in the line is detected, it issues the next 2-bit maneuver (veer right, veer left, turn around, stop) as a heading-offset request to the heading/PID controller. It gates motor enable and drives the piezo buzzer while a bumper reports an obstruction.

---
 rtl/maze_nav_sm.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/maze_nav_sm.sv
// Travel-plan sequencer for the MazeRunner: issues one 2-bit maneuver per qualified
// line gap, and stops the motors and sounds the piezo while a bumper is pressed.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no plan running; motors off; waits for cmd_rdy
// FOLLOW   | line following; counts line-absent cycles to qualify a gap
// MANEUVER | heading change in progress; counts line-present cycles to reacquire
// OBSTRUCT | bumper hit; motors off, buzzer on, waits for both bumpers released
module maze_nav_sm #(
    parameter int                 GAP_CLKS   = 4096,
    parameter int                 REACQ_CLKS = 1024,
    parameter int                 CLR_CLKS   = 4096,
    parameter int                 BUZZ_DIV   = 12500,
    parameter logic signed [12:0] VEER_ANG   = 13'sd350,
    parameter logic signed [12:0] TURN_ANG   = 13'sd1800
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        cmd,
    input  logic               cmd_rdy,
    output logic               clr_cmd_rdy,
    input  logic               line_present,
    input  logic               BMPL_n,
    input  logic               BMPR_n,
    output logic               go,
    output logic               strt_hdg,
    output logic signed [12:0] hdg_ofst,
    output logic               buzz,
    output logic               buzz_n,
    output logic               busy
);

    // Every timing parameter must be at least 2 so each counter has a nonzero width.
    localparam int GAP_W   = $clog2(GAP_CLKS);
    localparam int REACQ_W = $clog2(REACQ_CLKS);
    localparam int CLR_W   = $clog2(CLR_CLKS);
    localparam int BUZZ_W  = $clog2(BUZZ_DIV);

    localparam logic [GAP_W-1:0]   GAP_TC   = GAP_W'(GAP_CLKS - 1);
    localparam logic [REACQ_W-1:0] REACQ_TC = REACQ_W'(REACQ_CLKS - 1);
    localparam logic [CLR_W-1:0]   CLR_TC   = CLR_W'(CLR_CLKS - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_TC  = BUZZ_W'(BUZZ_DIV - 1);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FOLLOW   = 2'd1,
        MANEUVER = 2'd2,
        OBSTRUCT = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                ret_man, ret_man_nxt;
    logic [15:0]         plan, plan_nxt;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [REACQ_W-1:0]  reacq_cnt, reacq_nxt;
    logic [CLR_W-1:0]    clr_cnt, clr_nxt;
    logic [BUZZ_W-1:0]   buzz_cnt, buzz_cnt_nxt;
    logic                buzz_nxt;
    logic signed [12:0]  hdg_nxt;
    logic                strt_nxt;
    logic                ack_nxt;
    logic                bump;

    assign bump = ~BMPL_n | ~BMPR_n;

    always_comb begin
        state_nxt    = state;
        ret_man_nxt  = ret_man;
        plan_nxt     = plan;
        gap_nxt      = '0;
        reacq_nxt    = '0;
        clr_nxt      = '0;
        buzz_cnt_nxt = '0;
        buzz_nxt     = 1'b0;
        hdg_nxt      = hdg_ofst;
        strt_nxt     = 1'b0;
        ack_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_rdy) begin
                    plan_nxt  = cmd;
                    ack_nxt   = 1'b1;
                    state_nxt = FOLLOW;
                end
            end

            FOLLOW: begin
                if (bump) begin
                    state_nxt   = OBSTRUCT;
                    ret_man_nxt = 1'b0;
                end else if (!line_present) begin
                    if (gap_cnt == GAP_TC) begin
                        plan_nxt = {2'b00, plan[15:2]};
                        if (plan[1:0] == OP_STOP) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = MANEUVER;
                            strt_nxt  = 1'b1;
                            case (plan[1:0])
                                OP_RIGHT: hdg_nxt = VEER_ANG;
                                OP_LEFT:  hdg_nxt = -VEER_ANG;
                                default:  hdg_nxt = TURN_ANG;
                            endcase
                        end
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
            end

            MANEUVER: begin
                if (bump) begin
                    state_nxt   = OBSTRUCT;
                    ret_man_nxt = 1'b1;
                end else if (line_present) begin
                    if (reacq_cnt == REACQ_TC) begin
                        state_nxt = FOLLOW;
                    end else begin
                        reacq_nxt = reacq_cnt + 1'b1;
                    end
                end
            end

            OBSTRUCT: begin
                if (buzz_cnt == BUZZ_TC) begin
                    buzz_nxt = ~buzz;
                end else begin
                    buzz_cnt_nxt = buzz_cnt + 1'b1;
                    buzz_nxt     = buzz;
                end
                // Buzzer is silenced and its divider parked on the way out.
                if (BMPL_n && BMPR_n) begin
                    if (clr_cnt == CLR_TC) begin
                        state_nxt    = ret_man ? MANEUVER : FOLLOW;
                        buzz_cnt_nxt = '0;
                        buzz_nxt     = 1'b0;
                    end else begin
                        clr_nxt = clr_cnt + 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ret_man     <= 1'b0;
            plan        <= '0;
            gap_cnt     <= '0;
            reacq_cnt   <= '0;
            clr_cnt     <= '0;
            buzz_cnt    <= '0;
            buzz        <= 1'b0;
            buzz_n      <= 1'b0;
            hdg_ofst    <= '0;
            strt_hdg    <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            go          <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ret_man     <= ret_man_nxt;
            plan        <= plan_nxt;
            gap_cnt     <= gap_nxt;
            reacq_cnt   <= reacq_nxt;
            clr_cnt     <= clr_nxt;
            buzz_cnt    <= buzz_cnt_nxt;
            buzz        <= buzz_nxt;
            buzz_n      <= (state_nxt == OBSTRUCT) & ~buzz_nxt;
            hdg_ofst    <= hdg_nxt;
            strt_hdg    <= strt_nxt;
            clr_cmd_rdy <= ack_nxt;
            go          <= (state_nxt == FOLLOW) || (state_nxt == MANEUVER);
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule
